// File: rtl/mac_loop_offs_gen_pkg.sv
// ============================================================================
// Module   : mac_loop_offs_gen_pkg
// Purpose  : Shared constants, config/flag types and helpers for the MAC
//            loop-nest offset generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_loop_offs_gen_pkg;

    localparam int MAC_LOOP_N_LOOPS   = 2;
    localparam int MAC_LOOP_N_STREAMS = 4;
    localparam int MAC_LOOP_CNT_W     = 16;
    localparam int MAC_LOOP_OFFS_W    = 32;

    typedef logic [MAC_LOOP_CNT_W-1:0]  loop_cnt_t;
    typedef logic [MAC_LOOP_OFFS_W-1:0] loop_offs_t;

    typedef struct packed {
        loop_cnt_t  [MAC_LOOP_N_LOOPS-1:0]                         ranges;
        loop_offs_t [MAC_LOOP_N_LOOPS-1:0][MAC_LOOP_N_STREAMS-1:0] strides;
    } loop_cfg_t;

    typedef struct packed {
        loop_offs_t [MAC_LOOP_N_STREAMS-1:0] offs;
        logic                                valid;
        logic                                done;
        loop_cnt_t  [MAC_LOOP_N_LOOPS-1:0]   cnt;
    } loop_flags_t;

    // A programmed range of zero behaves as a single iteration.
    function automatic loop_cnt_t eff_range(input loop_cnt_t r);
        return (r == '0) ? loop_cnt_t'(1) : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_loop_offs_gen_if.sv
// ============================================================================
// Module   : mac_loop_offs_gen_if
// Purpose  : Control/config/flag bundle between the MAC control FSM (master)
//            and the loop offset generator (slave).
//            MAC_LOOP_LAST_INNER_EN adds last_inner_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_loop_offs_gen_if;
    import mac_loop_offs_gen_pkg::*;

    logic                                                        clear_i;
    logic                                                        enable_i;
    logic [MAC_LOOP_N_LOOPS*MAC_LOOP_CNT_W-1:0]                  range_i;
    logic [MAC_LOOP_N_LOOPS*MAC_LOOP_N_STREAMS*MAC_LOOP_OFFS_W-1:0] stride_i;
    logic [MAC_LOOP_N_STREAMS*MAC_LOOP_OFFS_W-1:0]               offs_o;
    logic                                                        valid_o;
    logic                                                        done_o;
    logic [MAC_LOOP_N_LOOPS*MAC_LOOP_CNT_W-1:0]                  cnt_o;
`ifdef MAC_LOOP_LAST_INNER_EN
    logic                                                        last_inner_o;
`endif

    modport master (
        output clear_i, enable_i, range_i, stride_i,
`ifdef MAC_LOOP_LAST_INNER_EN
        input  last_inner_o,
`endif
        input  offs_o, valid_o, done_o, cnt_o
    );

    modport slave (
        input  clear_i, enable_i, range_i, stride_i,
`ifdef MAC_LOOP_LAST_INNER_EN
        output last_inner_o,
`endif
        output offs_o, valid_o, done_o, cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/mac_loop_offs_gen_level.sv
// ============================================================================
// Module   : mac_loop_level
// Purpose  : One level of the loop nest: a counter plus the per-stream
//            partial offsets (cnt * stride) maintained incrementally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_loop_level
    import mac_loop_offs_gen_pkg::*;
(
    input  wire logic                                  clk_i,
    input  wire logic                                  rst_ni,
    input  wire logic                                  clear_i,
    input  wire logic                                  step_i,
    input  wire loop_cnt_t                             range_i,
    input  wire loop_offs_t [MAC_LOOP_N_STREAMS-1:0]   stride_i,
    output logic                                       at_last_o,
    output loop_cnt_t                                  cnt_o,
    output loop_offs_t [MAC_LOOP_N_STREAMS-1:0]        offs_o
);

    loop_cnt_t                             cnt_q, cnt_d;
    loop_offs_t [MAC_LOOP_N_STREAMS-1:0]   offs_q, offs_d;

    assign at_last_o = (cnt_q == (eff_range(range_i) - loop_cnt_t'(1)));
    assign cnt_o     = cnt_q;
    assign offs_o    = offs_q;

    // On wrap the counter returns to 0, so the partial offset is exactly 0.
    always_comb begin
        cnt_d  = cnt_q;
        offs_d = offs_q;
        if (clear_i) begin
            cnt_d  = '0;
            offs_d = '0;
        end else if (step_i) begin
            if (at_last_o) begin
                cnt_d  = '0;
                offs_d = '0;
            end else begin
                cnt_d = cnt_q + loop_cnt_t'(1);
                for (int s = 0; s < MAC_LOOP_N_STREAMS; s++) begin
                    offs_d[s] = offs_q[s] + stride_i[s];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            offs_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            offs_q <= offs_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_loop_offs_gen.sv
// ============================================================================
// Module   : mac_loop_offs_gen
// Purpose  : Nested-loop offset generator feeding the MAC control FSM.
//            Optional macro MAC_LOOP_LAST_INNER_EN adds last_inner_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_loop_offs_gen
    import mac_loop_offs_gen_pkg::*;
(
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    mac_loop_offs_gen_if.slave  bus
);

    localparam int N_LOOPS   = MAC_LOOP_N_LOOPS;
    localparam int N_STREAMS = MAC_LOOP_N_STREAMS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    loop_cfg_t   cfg_q, cfg_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic        [N_LOOPS-1:0]                 w_at_last;
    logic        [N_LOOPS-1:0]                 w_step_in;
    loop_cnt_t   [N_LOOPS-1:0]                 w_cnt;
    loop_offs_t  [N_LOOPS-1:0][N_STREAMS-1:0]  w_part;
    loop_offs_t  [N_STREAMS-1:0]               w_offs;
    loop_flags_t                               w_flags;
    logic                                      w_all_last;
    logic                                      w_accept;

    assign w_all_last = &w_at_last;
    assign w_accept   = bus.enable_i && !bus.clear_i;

    // The final enable only raises done; it never moves counters or offsets.
    assign w_step_in[0] = w_accept && (state_q != ST_DONE) && !w_all_last;

    generate
        for (genvar l = 1; l < N_LOOPS; l++) begin : g_carry
            assign w_step_in[l] = w_step_in[l-1] && w_at_last[l-1];
        end

        for (genvar l = 0; l < N_LOOPS; l++) begin : g_level
            mac_loop_level u_level (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clear_i   (bus.clear_i),
                .step_i    (w_step_in[l]),
                .range_i   (cfg_q.ranges[l]),
                .stride_i  (cfg_q.strides[l]),
                .at_last_o (w_at_last[l]),
                .cnt_o     (w_cnt[l]),
                .offs_o    (w_part[l])
            );
        end
    endgenerate

    always_comb begin
        w_offs = '0;
        for (int l = 0; l < N_LOOPS; l++) begin
            for (int s = 0; s < N_STREAMS; s++) begin
                w_offs[s] = w_offs[s] + w_part[l][s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        valid_d = 1'b0;
        done_d  = done_q;
        if (bus.clear_i) begin
            state_d        = ST_IDLE;
            cfg_d.ranges   = bus.range_i;
            cfg_d.strides  = bus.stride_i;
            done_d         = 1'b0;
        end else if (bus.enable_i) begin
            valid_d = 1'b1;
            case (state_q)
                ST_IDLE, ST_ITER: begin
                    if (w_all_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign w_flags.offs  = w_offs;
    assign w_flags.valid = valid_q;
    assign w_flags.done  = done_q;
    assign w_flags.cnt   = w_cnt;

    assign bus.offs_o  = w_flags.offs;
    assign bus.valid_o = w_flags.valid;
    assign bus.done_o  = w_flags.done;
    assign bus.cnt_o   = w_flags.cnt;

`ifdef MAC_LOOP_LAST_INNER_EN
    // Driven purely from level-0 flops and the latched range.
    assign bus.last_inner_o = w_at_last[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_loop_offs_gen.sv
// ============================================================================
// Module   : tb_mac_loop_offs_gen
// Purpose  : Directed self-checking bench for mac_loop_offs_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_loop_offs_gen;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mac_loop_offs_gen_if bus ();

    mac_loop_offs_gen dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] offs(input int s);
        return bus.offs_o[s*32 +: 32];
    endfunction

    task automatic set_cfg(input logic [15:0] r0, input logic [15:0] r1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] c0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [31:0] b1,
                           input logic [31:0] c1, input logic [31:0] d1);
        bus.range_i  = {r1, r0};
        bus.stride_i = {d1, c1, b1, a1, d0, c0, b0, a0};
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        bus.enable_i = 1'b1;
        @(negedge clk);
        bus.enable_i = 1'b0;
    endtask

    task automatic cfg_main();
        set_cfg(16'd3, 16'd2, 32'd8, 32'd8, 32'd0, 32'd32,
                32'd64, 32'd0, 32'd32, 32'd0);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.clear_i  = 1'b0;
        bus.enable_i = 1'b0;
        bus.range_i  = '0;
        bus.stride_i = '0;
        #12;
        n_cmp++;
        if (bus.offs_o !== '0) begin
            n_err++; $display("FAIL reset_offs: got %0h expected 0", bus.offs_o);
        end
        n_cmp++;
        if (bus.valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got v%0b d%0b expected v0 d0", bus.valid_o, bus.done_o);
        end
        n_cmp++;
        if (bus.cnt_o !== '0) begin
            n_err++; $display("FAIL reset_cnt: got %0h expected 0", bus.cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pulsed();
        logic [31:0] exp_a [6] = '{32'd8, 32'd16, 32'd64, 32'd72, 32'd80, 32'd80};
        logic [31:0] exp_d [6] = '{32'd32, 32'd64, 32'd0, 32'd32, 32'd64, 32'd64};
        logic [31:0] exp_c [6] = '{32'd0, 32'd0, 32'd32, 32'd32, 32'd32, 32'd32};
        logic [31:0] exp_n [6] = '{32'h0000_0001, 32'h0000_0002, 32'h0001_0000,
                                   32'h0001_0001, 32'h0001_0002, 32'h0001_0002};
        cfg_main();
        do_clear();
        n_cmp++;
        if (offs(0) !== 32'd0 || bus.valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL pulsed_iter0: got A=%0h v%0b d%0b expected A=0 v0 d0",
                              offs(0), bus.valid_o, bus.done_o);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.valid_o !== 1'b0) begin
                n_err++; $display("FAIL pulsed_gap%0d: got valid %0b expected 0", k, bus.valid_o);
            end
            bus.enable_i = 1'b1;
            @(negedge clk);
            bus.enable_i = 1'b0;
            n_cmp++;
            if (offs(0) !== exp_a[k] || offs(3) !== exp_d[k] || offs(2) !== exp_c[k]) begin
                n_err++; $display("FAIL pulsed_offs%0d: got A=%0h C=%0h D=%0h expected A=%0h C=%0h D=%0h",
                                  k, offs(0), offs(2), offs(3), exp_a[k], exp_c[k], exp_d[k]);
            end
            n_cmp++;
            if (bus.cnt_o !== exp_n[k] || bus.valid_o !== 1'b1 || bus.done_o !== (k == 5)) begin
                n_err++; $display("FAIL pulsed_flags%0d: got cnt=%0h v%0b d%0b expected cnt=%0h v1 d%0b",
                                  k, bus.cnt_o, bus.valid_o, bus.done_o, exp_n[k], (k == 5));
            end
        end
        pulse_enable();
        n_cmp++;
        if (bus.valid_o !== 1'b1 || bus.done_o !== 1'b1 || offs(0) !== 32'd80) begin
            n_err++; $display("FAIL done_hold: got v%0b d%0b A=%0h expected v1 d1 A=50",
                              bus.valid_o, bus.done_o, offs(0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a [8] = '{32'd8, 32'd16, 32'd64, 32'd72, 32'd80, 32'd80, 32'd80, 32'd80};
        cfg_main();
        do_clear();
        @(negedge clk);
        bus.enable_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.valid_o !== 1'b1 || bus.done_o !== (i >= 5) || offs(0) !== exp_a[i]) begin
                n_err++; $display("FAIL b2b_%0d: got v%0b d%0b A=%0h expected v1 d%0b A=%0h",
                                  i, bus.valid_o, bus.done_o, offs(0), (i >= 5), exp_a[i]);
            end
        end
        bus.enable_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_stop: got valid %0b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_zero_range();
        set_cfg(16'd0, 16'd0, 32'd8, 32'd8, 32'd8, 32'd8,
                32'd16, 32'd16, 32'd16, 32'd16);
        do_clear();
        pulse_enable();
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.valid_o !== 1'b1 || bus.offs_o !== '0 || bus.cnt_o !== '0) begin
            n_err++; $display("FAIL zero_range: got d%0b v%0b offs=%0h cnt=%0h expected d1 v1 offs=0 cnt=0",
                              bus.done_o, bus.valid_o, bus.offs_o, bus.cnt_o);
        end
    endtask

    task automatic test_neg_stride();
        logic [31:0] exp_a [4] = '{32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'hFFFF_FFD0, 32'hFFFF_FFD0};
        set_cfg(16'd4, 16'd1, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd0);
        do_clear();
        for (int k = 0; k < 4; k++) begin
            pulse_enable();
            n_cmp++;
            if (offs(0) !== exp_a[k] || bus.done_o !== (k == 3)) begin
                n_err++; $display("FAIL neg_stride%0d: got A=%0h d%0b expected A=%0h d%0b",
                                  k, offs(0), bus.done_o, exp_a[k], (k == 3));
            end
        end
    endtask

    task automatic test_clear_enable();
        cfg_main();
        do_clear();
        repeat (4) pulse_enable();
        n_cmp++;
        if (bus.cnt_o !== 32'h0001_0001) begin
            n_err++; $display("FAIL ce_pre: got cnt=%0h expected 10001", bus.cnt_o);
        end
        @(negedge clk);
        set_cfg(16'd5, 16'd1, 32'd4, 32'd0, 32'd0, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd0);
        bus.clear_i  = 1'b1;
        bus.enable_i = 1'b1;
        @(negedge clk);
        bus.clear_i  = 1'b0;
        bus.enable_i = 1'b0;
        n_cmp++;
        if (bus.cnt_o !== '0 || bus.offs_o !== '0 || bus.valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL ce_clear: got cnt=%0h offs=%0h v%0b d%0b expected all 0",
                              bus.cnt_o, bus.offs_o, bus.valid_o, bus.done_o);
        end
        set_cfg(16'd1, 16'd1, 32'd100, 32'd0, 32'd0, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd0);
        pulse_enable();
        n_cmp++;
        if (offs(0) !== 32'd4 || bus.cnt_o !== 32'h0000_0001 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL ce_latched: got A=%0h cnt=%0h d%0b expected A=4 cnt=1 d0",
                              offs(0), bus.cnt_o, bus.done_o);
        end
    endtask

    task automatic test_async_reset();
        cfg_main();
        do_clear();
        repeat (2) pulse_enable();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.offs_o !== '0 || bus.cnt_o !== '0 || bus.valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got offs=%0h cnt=%0h v%0b d%0b expected all 0",
                              bus.offs_o, bus.cnt_o, bus.valid_o, bus.done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef MAC_LOOP_LAST_INNER_EN
    task automatic test_last_inner();
        logic exp_li [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (bus.last_inner_o !== 1'b1) begin
            n_err++; $display("FAIL li_reset: got %0b expected 1", bus.last_inner_o);
        end
        cfg_main();
        do_clear();
        n_cmp++;
        if (bus.last_inner_o !== 1'b0) begin
            n_err++; $display("FAIL li_iter0: got %0b expected 0", bus.last_inner_o);
        end
        for (int k = 0; k < 5; k++) begin
            pulse_enable();
            n_cmp++;
            if (bus.last_inner_o !== exp_li[k]) begin
                n_err++; $display("FAIL li_%0d: got %0b expected %0b", k, bus.last_inner_o, exp_li[k]);
            end
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
`ifdef MAC_LOOP_LAST_INNER_EN
        test_last_inner();
`endif
        test_pulsed();
        test_back_to_back();
        test_zero_range();
        test_neg_stride();
        test_clear_enable();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
